// File: rtl/apple_generate.sv
// apple_generate: apple placement and eat detection for the snake game.
// Draws cells from a free-running LFSR and vets them against wall and snake.
module apple_generate #(
  parameter logic [5:0]  INIT_X    = 6'd24,
  parameter logic [4:0]  INIT_Y    = 5'd10,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic [5:0] head_x,
  input  logic [4:0] head_y,
  output logic       occ_req,
  output logic [5:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [5:0] apple_x,
  output logic [4:0] apple_y,
  output logic       apple_valid,
  output logic       apple_eaten,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    WAIT
  } state_t;

  localparam logic [15:0] POLY     = 16'hB400;
  localparam logic [6:0]  LAST_TRY = 7'(MAX_TRIES - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] lfsr;
  logic [6:0]  tries;
  logic [5:0]  hx;
  logic [4:0]  hy;
  logic [5:0]  cand_x;
  logic [4:0]  cand_y;
  logic        cand_ok;
  logic        eat;
  logic        reject;
  logic        give_up;

  assign cand_x  = lfsr[5:0];
  assign cand_y  = lfsr[12:8];
  assign cand_ok = (cand_x >= 6'd1) && (cand_x <= 6'd38) &&
                   (cand_y >= 5'd1) && (cand_y <= 5'd28);

  assign eat = move_tick && apple_valid &&
               (head_x == apple_x) && (head_y == apple_y);

  // The cell the snake just ate on is still under the head
  assign reject  = occ_hit || ((occ_x == hx) && (occ_y == hy));
  assign give_up = (tries == LAST_TRY);

  assign occ_req = (state == WAIT);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (eat) state_nx = DRAW;
      DRAW:    if (cand_ok) state_nx = WAIT;
      WAIT: begin
        if (occ_ack)
          state_nx = (reject && !give_up) ? DRAW : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= SEED;
      tries       <= '0;
      hx          <= '0;
      hy          <= '0;
      occ_x       <= '0;
      occ_y       <= '0;
      apple_x     <= INIT_X;
      apple_y     <= INIT_Y;
      apple_valid <= 1'b1;
      apple_eaten <= 1'b0;
    end else begin
      lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);
      state       <= state_nx;
      apple_eaten <= 1'b0;
      unique case (state)
        IDLE: begin
          if (eat) begin
            apple_eaten <= 1'b1;
            apple_valid <= 1'b0;
            tries       <= '0;
            hx          <= head_x;
            hy          <= head_y;
          end
        end
        DRAW: begin
          if (cand_ok) begin
            occ_x <= cand_x;
            occ_y <= cand_y;
          end
        end
        WAIT: begin
          if (occ_ack) begin
            if (reject && !give_up) begin
              tries <= tries + 7'd1;
            end else begin
              apple_x     <= occ_x;
              apple_y     <= occ_y;
              apple_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_generate.sv
// tb_apple_generate: scoreboard bench for apple_generate.
// Stimulus pushes predicted eat/placement events; a monitor pops and checks.
module tb_apple_generate;

  typedef struct {
    int         cyc;
    logic [5:0] x;
    logic [4:0] y;
  } place_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_tick = 1'b0;
  logic [5:0] head_x = '0;
  logic [4:0] head_y = '0;
  logic       occ_req;
  logic [5:0] occ_x;
  logic [4:0] occ_y;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic       apple_valid;
  logic       apple_eaten;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] m_lfsr;

  int   hit_n = 0;
  int   fin_delay = 0;
  int   q_total = 0;
  logic spur_ack = 1'b0;

  int     eat_q[$];
  place_t place_q[$];
  logic [5:0] exp_ax = 6'd24;
  logic [4:0] exp_ay = 5'd10;

  apple_generate dut (
    .clk(clk),
    .rst_n(rst_n),
    .move_tick(move_tick),
    .head_x(head_x),
    .head_y(head_y),
    .occ_req(occ_req),
    .occ_x(occ_x),
    .occ_y(occ_y),
    .occ_ack(occ_ack),
    .occ_hit(occ_hit),
    .apple_x(apple_x),
    .apple_y(apple_y),
    .apple_valid(apple_valid),
    .apple_eaten(apple_eaten),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Protocol-level prediction of where and when the next apple lands.
  // l0 is the LFSR value during the tick cycle; lat counts from that cycle.
  function automatic void predict(
    input  logic [15:0] l0,
    input  logic [5:0]  hx,
    input  logic [4:0]  hy,
    input  int          hn,
    input  int          fd,
    output logic [5:0]  ex,
    output logic [4:0]  ey,
    output int          lat,
    output int          nq
  );
    logic [15:0] v;
    logic [5:0]  cx;
    logic [4:0]  cy;
    int t, tries, d;
    bit rej, done;
    v = step(l0);
    t = 1;
    tries = 0;
    nq = 0;
    done = 0;
    ex = '0;
    ey = '0;
    lat = 0;
    while (!done && t < 5000) begin
      cx = v[5:0];
      cy = v[12:8];
      if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28) begin
        d   = (nq == hn) ? fd : 0;
        rej = (nq < hn) || (cx == hx && cy == hy);
        nq++;
        for (int k = 0; k < d + 2; k++) v = step(v);
        t = t + d + 2;
        if (rej && tries != 63) begin
          tries++;
        end else begin
          ex = cx;
          ey = cy;
          lat = t;
          done = 1;
        end
      end else begin
        v = step(v);
        t++;
      end
    end
  endfunction

  // Snake-body responder: answers queries after a per-query delay
  initial begin
    int q_idx;
    int wcnt;
    int d;
    q_idx = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
        q_idx = 0;
      end else begin
        if (!busy) q_idx = 0;
        if (spur_ack) begin
          occ_ack = 1'b1;
        end else if (occ_req) begin
          d = (q_idx == hit_n) ? fin_delay : 0;
          if (wcnt >= d) begin
            occ_ack = 1'b1;
            occ_hit = (q_idx < hit_n);
            q_idx++;
            q_total++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event
  initial begin
    logic       prev_valid;
    logic       prev_eaten;
    logic       prev_req;
    logic [5:0] px;
    logic [4:0] py;
    place_t     p;
    int         e;
    prev_valid = 1'b1;
    prev_eaten = 1'b0;
    prev_req = 1'b0;
    px = '0;
    py = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = apple_valid;
        prev_eaten = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (apple_eaten) begin
          check("eat_pending", int'(eat_q.size() > 0), 1);
          check("eat_pulse_width", int'(prev_eaten), 0);
          check("valid_low_on_eat", int'(apple_valid), 0);
          if (eat_q.size() > 0) begin
            e = eat_q.pop_front();
            check("eat_cycle", cyc, e);
          end
        end
        if (apple_valid && !prev_valid) begin
          check("place_pending", int'(place_q.size() > 0), 1);
          if (place_q.size() > 0) begin
            p = place_q.pop_front();
            check("place_cycle", cyc, p.cyc);
            check("apple_x", int'(apple_x), int'(p.x));
            check("apple_y", int'(apple_y), int'(p.y));
          end
          check("apple_in_range",
                int'(apple_x >= 6'd1 && apple_x <= 6'd38 &&
                     apple_y >= 5'd1 && apple_y <= 5'd28), 1);
        end
        if (occ_req && prev_req) begin
          check("occ_x_stable", int'(occ_x), int'(px));
          check("occ_y_stable", int'(occ_y), int'(py));
        end
        prev_valid = apple_valid;
        prev_eaten = apple_eaten;
        prev_req = occ_req;
        px = occ_x;
        py = occ_y;
      end
    end
  end

  task automatic eat_at(
    input  logic [5:0] hx,
    input  logic [4:0] hy,
    input  int         hn,
    input  int         fd,
    output int         nq
  );
    place_t p;
    int lat;
    hit_n = hn;
    fin_delay = fd;
    @(posedge clk);
    #2;
    move_tick = 1'b1;
    head_x = hx;
    head_y = hy;
    predict(m_lfsr, hx, hy, hn, fd, p.x, p.y, lat, nq);
    p.cyc = cyc + lat;
    eat_q.push_back(cyc + 1);
    place_q.push_back(p);
    exp_ax = p.x;
    exp_ay = p.y;
    @(posedge clk);
    #2;
    move_tick = 1'b0;
  endtask

  task automatic wait_place(input string name);
    int n;
    n = 0;
    while (place_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check({name, "_done"}, place_q.size(), 0);
    place_q.delete();
    eat_q.delete();
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!occ_req && n < 500);
    check({name, "_req_seen"}, int'(occ_req), 1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_apple_x"}, int'(apple_x), 24);
    check({name, "_apple_y"}, int'(apple_y), 10);
    check({name, "_valid"}, int'(apple_valid), 1);
    check({name, "_occ_req"}, int'(occ_req), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_eaten"}, int'(apple_eaten), 0);
    check({name, "_occ_x"}, int'(occ_x), 0);
    check({name, "_occ_y"}, int'(occ_y), 0);
  endtask

  initial begin
    int nq;
    int q0;
    logic [5:0] ox;
    logic [4:0] oy;

    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    rst_n = 1'b1;

    // Near-miss one row below the apple
    @(posedge clk);
    #2;
    move_tick = 1'b1;
    head_x = 6'd24;
    head_y = 5'd11;
    @(posedge clk);
    #2;
    move_tick = 1'b0;
    check("near_miss_busy", int'(busy), 0);
    check("near_miss_valid", int'(apple_valid), 1);

    // Basic eat with immediate free answer
    q0 = q_total;
    eat_at(6'd24, 5'd10, 0, 0, nq);
    wait_place("basic");
    check("basic_queries", q_total - q0, nq);

    // Two occupied answers, then a slow free answer
    q0 = q_total;
    eat_at(exp_ax, exp_ay, 2, 5, nq);
    wait_place("reject");
    check("reject_queries", q_total - q0, nq);

    // Tick on the old cell while waiting, then a stray ack in IDLE
    ox = exp_ax;
    oy = exp_ay;
    eat_at(ox, oy, 0, 10, nq);
    wait_req("ignore");
    move_tick = 1'b1;
    head_x = ox;
    head_y = oy;
    @(posedge clk);
    #2;
    move_tick = 1'b0;
    check("ignore_tick_busy", int'(busy), 1);
    wait_place("ignore");
    spur_ack = 1'b1;
    @(posedge clk);
    #2;
    spur_ack = 1'b0;
    @(posedge clk);
    #2;
    check("spur_ack_busy", int'(busy), 0);
    check("spur_ack_x", int'(apple_x), int'(exp_ax));
    check("spur_ack_y", int'(apple_y), int'(exp_ay));
    check("spur_ack_valid", int'(apple_valid), 1);

    // Every answer occupied: the last allowed candidate is forced in
    q0 = q_total;
    eat_at(exp_ax, exp_ay, 64, 0, nq);
    wait_place("forced");
    check("forced_queries", q_total - q0, 64);

    // Reset in the middle of a query
    eat_at(exp_ax, exp_ay, 0, 20, nq);
    wait_req("mid_wait");
    rst_n = 1'b0;
    eat_q.delete();
    place_q.delete();
    #1;
    check_reset("rst_async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_reset("rst_release");

    // LFSR restarted from the seed: model and DUT must agree again
    q0 = q_total;
    eat_at(6'd24, 5'd10, 0, 0, nq);
    wait_place("post_reset");
    check("post_reset_queries", q_total - q0, nq);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
